// File: rtl/gen_bus_ram_responder.sv
// gen_bus_ram_responder: generic-bus responder with word RAM, wait states, fault checks (optional stats via GEN_BUS_RAM_STATS_EN)
module gen_bus_ram_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int DEPTH = 1024,
  parameter int WAIT_STATES = 2
) (
  input logic CLK,
  input logic RST,
  input logic ren,
  input logic wen,
  input logic [31:0] addr,
  input logic [31:0] wdata,
  input logic [3:0] byte_en,
  output logic [31:0] rdata,
  output logic busy,
  output logic error
`ifdef GEN_BUS_RAM_STATS_EN
  ,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count,
  output logic [15:0] err_count
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [32:0] SPAN = 33'(DEPTH) << 2;
  localparam logic [3:0] CNT0 = WAIT_STATES == 0 ? 4'd0 : 4'(WAIT_STATES - 1);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [31:0] mem [DEPTH];
  logic [32:0] off;
  logic [AW-1:0] idx_live, idx_q, idx_s;
  logic [31:0] wdata_q, mask_s;
  logic [3:0] be_q, be_s;
  logic wr_q, fault_q, fault_live, fault_s, req, accept, be_ok, commit, unused_ok;
  assign req = ren | wen;
  assign accept = state == IDLE && req;
  assign off = {1'b0, addr} - {1'b0, BASE_ADDR};
  assign idx_live = off[AW+1:2];
  assign unused_ok = ^{off[32:AW+2], off[1:0]};
  assign be_ok = byte_en == 4'b1111 ? addr[1:0] == 2'b00 :
                 (byte_en == 4'b0011 || byte_en == 4'b1100) ? !addr[0] : $onehot(byte_en);
  assign fault_live = off >= SPAN || !be_ok || (ren && wen);
  assign idx_s = state == IDLE ? idx_live : idx_q;
  assign be_s = state == IDLE ? byte_en : be_q;
  assign fault_s = state == IDLE ? fault_live : fault_q;
  assign mask_s = {{8{be_s[3]}}, {8{be_s[2]}}, {8{be_s[1]}}, {8{be_s[0]}}};
  assign commit = state == RESP && wen && wr_q && !fault_q;
  assign busy = state != RESP;
  assign error = state == RESP && fault_q;
  // next state: accept in IDLE, count down or abort in WAIT, single RESP cycle
  always_comb begin
    state_n = state == IDLE ? (req ? (WAIT_STATES == 0 ? RESP : WAIT) : IDLE) :
              state == WAIT ? (!req ? IDLE : cnt == 4'd0 ? RESP : WAIT) : IDLE;
    cnt_n = accept ? CNT0 : (state == WAIT && req && cnt != 4'd0) ? cnt - 4'd1 : 4'd0;
  end
  // state register
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state <= IDLE;
      cnt <= 4'd0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
    end
  // latch request on accept; load read data on the edge entering RESP
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      rdata <= 32'd0;
      idx_q <= '0;
      wdata_q <= 32'd0;
      be_q <= 4'd0;
      wr_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      if (accept) begin
        idx_q <= idx_live;
        wdata_q <= wdata;
        be_q <= byte_en;
        wr_q <= wen;
        fault_q <= fault_live;
      end
      if (state_n == RESP) rdata <= fault_s ? 32'd0 : mem[idx_s] & mask_s;
    end
  // RAM write on the edge leaving RESP, enabled lanes only; contents never reset
  always_ff @(posedge CLK)
    if (commit)
      for (int i = 0; i < 4; i++)
        if (be_q[i]) mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
`ifdef GEN_BUS_RAM_STATS_EN
  // completion counters updated on the edge leaving RESP
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      rd_count <= 32'd0;
      wr_count <= 32'd0;
      err_count <= 16'd0;
    end else if (state == RESP) begin
      if (fault_q) err_count <= err_count + {15'd0, err_count != 16'hFFFF};
      else if (commit) wr_count <= wr_count + 32'd1;
      else if (!wr_q) rd_count <= rd_count + 32'd1;
    end
`endif
endmodule

// File: tb/tb_gen_bus_ram_responder.sv
// tb_gen_bus_ram_responder: vector table, corner sequences and random traffic against a RAM model
module tb_gen_bus_ram_responder;
  localparam logic [31:0] B = 32'h0000_1000;
  localparam int D = 16;
  localparam int WS = 2;
  logic CLK = 1'b0, RST = 1'b1;
  logic ren = 0, wen = 0, ren2 = 0, wen2 = 0;
  logic [31:0] addr = 0, wdata = 0, addr2 = 0, wdata2 = 0;
  logic [3:0] byte_en = 0, byte_en2 = 0;
  logic [31:0] rdata, rdata2;
  logic busy, error, busy2, error2;
`ifdef GEN_BUS_RAM_STATS_EN
  logic [31:0] rd_count, wr_count, rd_count2, wr_count2;
  logic [15:0] err_count, err_count2;
`endif
  int checks = 0, errors = 0;
  logic [31:0] mm [D];
  int m_rd = 0, m_wr = 0, m_err = 0;
  always #5 CLK = ~CLK;
  gen_bus_ram_responder #(.BASE_ADDR(B), .DEPTH(D), .WAIT_STATES(WS)) dut (
    .CLK(CLK), .RST(RST), .ren(ren), .wen(wen), .addr(addr), .wdata(wdata), .byte_en(byte_en),
    .rdata(rdata), .busy(busy), .error(error)
`ifdef GEN_BUS_RAM_STATS_EN
    , .rd_count(rd_count), .wr_count(wr_count), .err_count(err_count)
`endif
  );
  gen_bus_ram_responder #(.BASE_ADDR(32'h0), .DEPTH(D), .WAIT_STATES(0)) dut0 (
    .CLK(CLK), .RST(RST), .ren(ren2), .wen(wen2), .addr(addr2), .wdata(wdata2), .byte_en(byte_en2),
    .rdata(rdata2), .busy(busy2), .error(error2)
`ifdef GEN_BUS_RAM_STATS_EN
    , .rd_count(rd_count2), .wr_count(wr_count2), .err_count(err_count2)
`endif
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  function automatic bit mfault(input logic r, input logic w, input logic [31:0] a, input logic [3:0] be);
    longint ua = longint'(a);
    bit rng = ua < longint'(B) || ua >= longint'(B) + 4 * D;
    bit ok = (be inside {4'd1, 4'd2, 4'd4, 4'd8}) || ((be == 4'd3 || be == 4'd12) && a % 2 == 0) ||
             (be == 4'd15 && a % 4 == 0);
    return rng || !ok || (r && w);
  endfunction
  function automatic logic [31:0] lanes(input logic [3:0] be);
    logic [31:0] m = 0;
    for (int i = 0; i < 4; i++) if (be[i]) m |= 32'hFF << (8 * i);
    return m;
  endfunction
  task automatic txn(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] be, input logic e, input logic [31:0] q, input bit cq, input string nm);
    int c = 0;
    bit done = 0;
    bit f = mfault(r, w, a, be);
    int ix = f ? 0 : int'((a - B) / 4);
    @(negedge CLK);
    ren = r; wen = w; addr = a; wdata = d; byte_en = be;
    while (!done && c < 40) begin
      @(negedge CLK);
      c++;
      if (!busy) done = 1;
    end
    chk({nm, " latency"}, c, WS + 1);
    chk({nm, " error"}, {31'd0, error}, {31'd0, e});
    if (cq) chk({nm, " rdata"}, rdata, q);
    @(negedge CLK);
    chk({nm, " busy after"}, {31'd0, busy}, 32'd1);
    ren = 0; wen = 0;
    if (!f && w) mm[ix] = (mm[ix] & ~lanes(be)) | (d & lanes(be));
    if (f) m_err = m_err < 16'hFFFF ? m_err + 1 : m_err;
    else if (w) m_wr++;
    else m_rd++;
  endtask
  task automatic chk_stats(input string nm);
`ifdef GEN_BUS_RAM_STATS_EN
    chk({nm, " rd_count"}, rd_count, m_rd);
    chk({nm, " wr_count"}, wr_count, m_wr);
    chk({nm, " err_count"}, {16'd0, err_count}, m_err);
`endif
  endtask
  typedef struct {
    logic r, w;
    logic [31:0] a, d;
    logic [3:0] be;
    logic e;
    logic [31:0] q;
    bit cq;
  } vec_t;
  vec_t tv [15];
  initial begin
    tv[0]  = '{1'b0, 1'b1, 32'h1008, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0, 1'b0};
    tv[1]  = '{1'b1, 1'b0, 32'h1008, 32'h0, 4'hF, 1'b0, 32'hDEADBEEF, 1'b1};
    tv[2]  = '{1'b0, 1'b1, 32'h1009, 32'h0000AA00, 4'h2, 1'b0, 32'h0, 1'b0};
    tv[3]  = '{1'b1, 1'b0, 32'h1008, 32'h0, 4'hF, 1'b0, 32'hDEADAAEF, 1'b1};
    tv[4]  = '{1'b1, 1'b0, 32'h1040, 32'h0, 4'hF, 1'b1, 32'h0, 1'b1};
    tv[5]  = '{1'b1, 1'b1, 32'h1008, 32'h12345678, 4'hF, 1'b1, 32'h0, 1'b1};
    tv[6]  = '{1'b1, 1'b0, 32'h1008, 32'h0, 4'hF, 1'b0, 32'hDEADAAEF, 1'b1};
    tv[7]  = '{1'b1, 1'b0, 32'h100A, 32'h0, 4'hF, 1'b1, 32'h0, 1'b1};
    tv[8]  = '{1'b1, 1'b0, 32'h100A, 32'h0, 4'hC, 1'b0, 32'hDEAD0000, 1'b1};
    tv[9]  = '{1'b1, 1'b0, 32'h0FFC, 32'h0, 4'hF, 1'b1, 32'h0, 1'b1};
    tv[10] = '{1'b1, 1'b0, 32'h1008, 32'h0, 4'h0, 1'b1, 32'h0, 1'b1};
    tv[11] = '{1'b1, 1'b0, 32'h1008, 32'h0, 4'h5, 1'b1, 32'h0, 1'b1};
    tv[12] = '{1'b0, 1'b1, 32'h1009, 32'hFFFFFFFF, 4'h3, 1'b1, 32'h0, 1'b0};
    tv[13] = '{1'b1, 1'b0, 32'h1008, 32'h0, 4'hF, 1'b0, 32'hDEADAAEF, 1'b1};
    tv[14] = '{1'b1, 1'b0, 32'h1009, 32'h0, 4'h2, 1'b0, 32'h0000AA00, 1'b1};
    repeat (3) @(negedge CLK);
    chk("reset busy", {31'd0, busy}, 32'd1);
    chk("reset error", {31'd0, error}, 32'd0);
    chk("reset rdata", rdata, 32'd0);
    chk("reset busy ws0", {31'd0, busy2}, 32'd1);
    RST = 0;
    for (int i = 0; i < 15; i++) txn(tv[i].r, tv[i].w, tv[i].a, tv[i].d, tv[i].be, tv[i].e, tv[i].q, tv[i].cq, $sformatf("vec%0d", i));
    chk_stats("table");
    for (int i = 0; i < D; i++) txn(1'b0, 1'b1, B + 4 * i, $urandom, 4'hF, 1'b0, 32'h0, 1'b0, "fill");
    @(negedge CLK);
    ren = 1; addr = B + 8; byte_en = 4'hF;
    for (int i = 1; i <= 6; i++) begin
      @(negedge CLK);
      if (i == 1) ren = 0;
      chk("abort busy", {31'd0, busy}, 32'd1);
      chk("abort error", {31'd0, error}, 32'd0);
    end
    txn(1'b1, 1'b0, B + 8, 32'h0, 4'hF, 1'b0, mm[2], 1'b1, "after abort");
    chk_stats("abort");
    @(negedge CLK);
    wen = 1; addr = B + 8; wdata = 32'h11111111; byte_en = 4'hF;
    @(negedge CLK);
    RST = 1;
    #1;
    chk("mid reset busy", {31'd0, busy}, 32'd1);
    chk("mid reset error", {31'd0, error}, 32'd0);
    chk("mid reset rdata", rdata, 32'd0);
    @(negedge CLK);
    RST = 0; wen = 0;
    m_rd = 0; m_wr = 0; m_err = 0;
    txn(1'b1, 1'b0, B + 8, 32'h0, 4'hF, 1'b0, mm[2], 1'b1, "after reset");
    @(negedge CLK);
    wen2 = 1; addr2 = 0; wdata2 = 32'hCAFEF00D; byte_en2 = 4'hF;
    @(negedge CLK);
    chk("ws0 write busy", {31'd0, busy2}, 32'd0);
    chk("ws0 write error", {31'd0, error2}, 32'd0);
    @(negedge CLK);
    chk("ws0 write busy after", {31'd0, busy2}, 32'd1);
    wen2 = 0; ren2 = 1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge CLK);
      chk($sformatf("ws0 b2b busy c%0d", i), {31'd0, busy2}, {31'd0, i % 2 == 0});
      if (i % 2 == 1) chk($sformatf("ws0 b2b rdata c%0d", i), rdata2, 32'hCAFEF00D);
    end
    ren2 = 0;
`ifdef GEN_BUS_RAM_STATS_EN
    chk("ws0 rd_count", rd_count2, 32'd3);
    chk("ws0 wr_count", wr_count2, 32'd1);
    chk("ws0 err_count", {16'd0, err_count2}, 32'd0);
`endif
    for (int n = 0; n < 250; n++) begin
      int op = $urandom_range(0, 9);
      int k = $urandom_range(0, 9);
      logic r = op == 0 || op > 4;
      logic w = op <= 4;
      logic [31:0] a = B - 8 + $urandom_range(0, 4 * D + 15);
      logic [3:0] be = k < 4 ? 4'(1 << k) : k == 4 ? 4'h3 : k == 5 ? 4'hC : k < 9 ? 4'hF : 4'($urandom);
      bit f = mfault(r, w, a, be);
      logic [31:0] q = f ? 32'h0 : mm[int'((a - B) / 4)] & lanes(be);
      txn(r, w, a, $urandom, be, f, q, (r && !w) || f, "rand");
    end
    chk_stats("random");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
